tcp_rt_timer_table: RTL and testbench
=====================================

# tcp_rt_timer_table

Per-flow retransmission-timer and duplicate-ACK tracker for the TCP engine. It replaces the single-flow timer/ack-state structs with a parametrised table covering NUM_FLOWS flows. Each flow has an armed timer with a start timestamp and a last-ACK/dup-count entry. The block raises a queued retransmit request per flow on timeout or on reaching the fast-retransmit threshold. It sits between the RX ACK-processing path, the TX send path, and the TX retransmit scheduler.

## Interface
Parameters:
- NUM_FLOWS, 8, number of tracked flows (≥2)
- FLOWID_W, $clog2(NUM_FLOWS), flow index width
- TIMESTAMP_W, 64, free-running time counter width
- TIMEOUT_CYCLES, 250000000, retransmit timeout in cycles (≥ NUM_FLOWS)
- ACK_NUM_W, 32, ACK number width
- DUP_ACK_CNT_W, 4, dup-ACK counter width
- DUP_ACK_RT, 3, dup-ACK count that triggers fast retransmit (1 ≤ DUP_ACK_RT < 2^DUP_ACK_CNT_W)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- arm_val  in  1  arm/re-arm timer of arm_flowid with timestamp = curr_time
- arm_flowid  in  FLOWID_W  flow to arm
- disarm_val  in  1  disarm timer and clear pending requests of disarm_flowid
- disarm_flowid  in  FLOWID_W  flow to disarm
- ack_val  in  1  ACK received for ack_flowid
- ack_flowid  in  FLOWID_W  flow of received ACK
- ack_num  in  ACK_NUM_W  ACK number received
- rt_req_val  out  1  retransmit request valid
- rt_req_flowid  out  FLOWID_W  flow to retransmit
- rt_req_cause  out  1  0 = timeout, 1 = fast retransmit
- rt_req_rdy  in  1  scheduler accepts request
- curr_time  out  TIMESTAMP_W  free-running cycle counter

## Operation
- Per-flow state: armed, timestamp, last_ack, dup_cnt, pend_to, pend_fr.
- curr_time increments every cycle and wraps modulo 2^TIMESTAMP_W.
- Arm sets armed=1 and timestamp=curr_time. dup state is untouched.
- Disarm sets armed=0 and clears pend_to/pend_fr. A request already held on the output is unaffected.
- Same flow on arm and disarm in one cycle: disarm wins.
- ACK with ack_num == last_ack while armed: dup_cnt increments, saturating at all-ones. The transition DUP_ACK_RT-1 → DUP_ACK_RT sets pend_fr (once per episode).
- ACK with ack_num != last_ack: last_ack=ack_num and dup_cnt=0. If armed and not arming in the same cycle, timestamp=curr_time.
- ACK while disarmed with an equal ack_num: no change.
- Scanner: pointer scan_idx cycles 0..NUM_FLOWS-1, one flow per cycle. The check is (curr_time − timestamp) mod 2^TIMESTAMP_W ≥ TIMEOUT_CYCLES.
  - If the check passes while armed: set pend_to and restart timestamp=curr_time. The timer stays armed.
  - An arm, disarm or ACK-timer-restart on the scanned flow in the same cycle suppresses the timeout.
- Output register (empty/full):
  - Loads when empty, or when full and rt_req_rdy=1.
  - Selects the first flow with any pending bit, searching round-robin starting at last granted flow+1.
  - For the selected flow, pend_fr takes priority over pend_to. Only the selected bit is cleared; the other stays for a later grant.
  - Pending bits set this cycle are not visible to selection until the next cycle.

## Timing
- Reset values:
  - all armed/pend bits 0, last_ack=0, dup_cnt=0, timestamps 0
  - curr_time=0, scan_idx=0, last grant=NUM_FLOWS-1
  - rt_req_val=0, rt_req_flowid=0, rt_req_cause=0
- Reset mid-operation drops any held request; rt_req_val is 0 on the next cycle.
- Timeout detection latency: at most NUM_FLOWS cycles after expiry.
- Pending set at edge N → rt_req_val=1 at edge N+1 at earliest, if the output is free.
- Handshake:
  - rt_req_val, once high, holds with stable flowid/cause until the cycle rt_req_rdy=1.
  - Back-to-back transfers are sustained at one per cycle while requests are pending.
- Arm/disarm/ACK take effect at the next edge. Table reads see pre-edge state.

## Test plan
Bench settings: NUM_FLOWS=4, TIMEOUT_CYCLES=100, DUP_ACK_RT=3, rt_req_rdy=1 unless stated.
- Reset then idle 300 cycles → rt_req_val stays 0; curr_time=300.
- Arm flow 2 at t=10, no ACKs → one timeout request (flowid 2, cause 0) between t=110 and t=115, and another ~100 cycles later.
- Arm flow 1, ACK 1000, then ACK 1000 ×3 → exactly one request (flowid 1, cause 1) after the third duplicate. A fourth duplicate produces none; dup_cnt=4.
- Arm flow 0, new ACKs every 50 cycles for 500 cycles → no timeout request. Disarm flow 3 while its timeout is pending → the request is never issued.
- Flows 0–3 all timed out with rt_req_rdy=0 for 20 cycles → rt_req_val held with a stable flowid. Releasing rdy grants all four round-robin, one per cycle.
- Flow 2 with both pend_fr and pend_to set → grant cause 1 first, then cause 0 on a later grant. Reset asserted while rt_req_val=1 → rt_req_val=0 on the next cycle.

Source files
------------

// File: rtl/tcp_rt_timer_table.sv
// Per-flow TCP retransmission timer and duplicate-ACK tracker. Timeout and
// fast-retransmit events are queued per flow and granted round-robin.
module tcp_rt_timer_table #(
    parameter int NUM_FLOWS      = 8,
    parameter int FLOWID_W       = $clog2(NUM_FLOWS),
    parameter int TIMESTAMP_W    = 64,
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int ACK_NUM_W      = 32,
    parameter int DUP_ACK_CNT_W  = 4,
    parameter int DUP_ACK_RT     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm_val,
    input  logic [FLOWID_W-1:0]    arm_flowid,
    input  logic                   disarm_val,
    input  logic [FLOWID_W-1:0]    disarm_flowid,
    input  logic                   ack_val,
    input  logic [FLOWID_W-1:0]    ack_flowid,
    input  logic [ACK_NUM_W-1:0]   ack_num,
    output logic                   rt_req_val,
    output logic [FLOWID_W-1:0]    rt_req_flowid,
    output logic                   rt_req_cause,
    input  logic                   rt_req_rdy,
    output logic [TIMESTAMP_W-1:0] curr_time
);

    localparam logic [TIMESTAMP_W-1:0]   TIMEOUT_T = TIMESTAMP_W'(TIMEOUT_CYCLES);
    localparam logic [DUP_ACK_CNT_W-1:0] DUP_PRE   = DUP_ACK_CNT_W'(DUP_ACK_RT - 1);
    localparam logic [FLOWID_W-1:0]      LAST_FLOW = FLOWID_W'(NUM_FLOWS - 1);

    logic [TIMESTAMP_W-1:0] curr_time_reg;
    logic [FLOWID_W-1:0]    scan_idx_reg;
    logic [FLOWID_W-1:0]    last_grant_reg;
    logic                   rt_req_val_reg;
    logic [FLOWID_W-1:0]    rt_req_flowid_reg;
    logic                   rt_req_cause_reg;

    logic [NUM_FLOWS-1:0]   pend_to_vec;
    logic [NUM_FLOWS-1:0]   pend_fr_vec;

    logic                   load;
    logic                   grant;
    logic                   sel_found;
    logic                   sel_cause;
    logic [FLOWID_W-1:0]    sel_idx;
    int                     cand;
    logic [FLOWID_W-1:0]    cand_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            curr_time_reg <= '0;
            scan_idx_reg  <= '0;
        end else begin
            curr_time_reg <= curr_time_reg + TIMESTAMP_W'(1);
            scan_idx_reg  <= (scan_idx_reg == LAST_FLOW) ? '0 : scan_idx_reg + FLOWID_W'(1);
        end
    end

    // Round-robin search starting one past the most recently granted flow.
    always_comb begin
        sel_found = 1'b0;
        sel_cause = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_FLOWS; k++) begin
            cand     = (int'(last_grant_reg) + 1 + k) % NUM_FLOWS;
            cand_idx = cand[FLOWID_W-1:0];
            if (!sel_found && (pend_to_vec[cand_idx] || pend_fr_vec[cand_idx])) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
                sel_cause = pend_fr_vec[cand_idx];
            end
        end
    end

    assign load  = !rt_req_val_reg || rt_req_rdy;
    assign grant = load && sel_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            rt_req_val_reg    <= 1'b0;
            rt_req_flowid_reg <= '0;
            rt_req_cause_reg  <= 1'b0;
            last_grant_reg    <= LAST_FLOW;
        end else if (load) begin
            rt_req_val_reg <= sel_found;
            if (sel_found) begin
                rt_req_flowid_reg <= sel_idx;
                rt_req_cause_reg  <= sel_cause;
                last_grant_reg    <= sel_idx;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_FLOWS; gi++) begin : g_flow
        localparam logic [FLOWID_W-1:0] ID = FLOWID_W'(gi);

        logic                     armed_reg;
        logic [TIMESTAMP_W-1:0]   ts_reg;
        logic [ACK_NUM_W-1:0]     last_ack_reg;
        logic [DUP_ACK_CNT_W-1:0] dup_cnt_reg;
        logic                     pend_to_reg;
        logic                     pend_fr_reg;

        logic disarm_hit, arm_hit, ack_hit, ack_new, ack_dup;
        logic ts_restart, fr_hit, timeout_hit, clr_to, clr_fr;

        assign disarm_hit = disarm_val && (disarm_flowid == ID);
        assign arm_hit    = arm_val && (arm_flowid == ID);
        assign ack_hit    = ack_val && (ack_flowid == ID);
        assign ack_new    = ack_hit && (ack_num != last_ack_reg);
        assign ack_dup    = ack_hit && (ack_num == last_ack_reg) && armed_reg;
        assign ts_restart = ack_new && armed_reg && !arm_hit;
        assign fr_hit     = ack_dup && (dup_cnt_reg == DUP_PRE);
        // Any same-cycle timer update on the scanned flow takes precedence over expiry.
        assign timeout_hit = armed_reg && (scan_idx_reg == ID)
                             && ((curr_time_reg - ts_reg) >= TIMEOUT_T)
                             && !arm_hit && !disarm_hit && !ts_restart;
        assign clr_fr = grant && (sel_idx == ID) && sel_cause;
        assign clr_to = grant && (sel_idx == ID) && !sel_cause;

        always_ff @(posedge clk) begin
            if (rst) begin
                armed_reg    <= 1'b0;
                ts_reg       <= '0;
                last_ack_reg <= '0;
                dup_cnt_reg  <= '0;
                pend_to_reg  <= 1'b0;
                pend_fr_reg  <= 1'b0;
            end else begin
                if (disarm_hit)
                    armed_reg <= 1'b0;
                else if (arm_hit)
                    armed_reg <= 1'b1;

                if (arm_hit || ts_restart || timeout_hit)
                    ts_reg <= curr_time_reg;

                if (ack_new) begin
                    last_ack_reg <= ack_num;
                    dup_cnt_reg  <= '0;
                end else if (ack_dup && (dup_cnt_reg != '1)) begin
                    dup_cnt_reg <= dup_cnt_reg + DUP_ACK_CNT_W'(1);
                end

                if (disarm_hit)
                    pend_fr_reg <= 1'b0;
                else if (fr_hit)
                    pend_fr_reg <= 1'b1;
                else if (clr_fr)
                    pend_fr_reg <= 1'b0;

                if (disarm_hit)
                    pend_to_reg <= 1'b0;
                else if (timeout_hit)
                    pend_to_reg <= 1'b1;
                else if (clr_to)
                    pend_to_reg <= 1'b0;
            end
        end

        assign pend_to_vec[gi] = pend_to_reg;
        assign pend_fr_vec[gi] = pend_fr_reg;
    end

    assign rt_req_val    = rt_req_val_reg;
    assign rt_req_flowid = rt_req_flowid_reg;
    assign rt_req_cause  = rt_req_cause_reg;
    assign curr_time     = curr_time_reg;

endmodule

// File: tb/tb_tcp_rt_timer_table.sv
// Directed bench for tcp_rt_timer_table: a per-cycle vector table for the
// dup-ACK path plus hand-written timeout, round-robin and reset sequences.
module tb_tcp_rt_timer_table;

    localparam int NF = 4;
    localparam int FW = 2;
    localparam int TW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm_val, disarm_val, ack_val;
    logic [FW-1:0] arm_flowid, disarm_flowid, ack_flowid;
    logic [AW-1:0] ack_num;
    logic          rt_req_val;
    logic [FW-1:0] rt_req_flowid;
    logic          rt_req_cause;
    logic          rt_req_rdy;
    logic [TW-1:0] curr_time;

    always #5 clk = ~clk;

    tcp_rt_timer_table #(
        .NUM_FLOWS(NF), .FLOWID_W(FW), .TIMESTAMP_W(TW), .TIMEOUT_CYCLES(100),
        .ACK_NUM_W(AW), .DUP_ACK_CNT_W(4), .DUP_ACK_RT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .arm_val(arm_val), .arm_flowid(arm_flowid),
        .disarm_val(disarm_val), .disarm_flowid(disarm_flowid),
        .ack_val(ack_val), .ack_flowid(ack_flowid), .ack_num(ack_num),
        .rt_req_val(rt_req_val), .rt_req_flowid(rt_req_flowid),
        .rt_req_cause(rt_req_cause), .rt_req_rdy(rt_req_rdy),
        .curr_time(curr_time)
    );

    typedef struct {
        logic          arm;
        logic          disarm;
        logic          ack;
        logic [FW-1:0] flow;
        logic [AW-1:0] num;
        logic          rdy;
        logic          exp_val;
        logic [FW-1:0] exp_flow;
        logic          exp_cause;
    } vec_t;

    typedef struct {
        int cyc;
        int flow;
        int cause;
    } grant_t;

    vec_t   vecs[29];
    grant_t grants[$];
    int     cyc;
    int     checks = 0;
    int     errors = 0;

    function automatic vec_t mk(logic arm, logic dis, logic ack, int flow, int num,
                                logic rdy, logic ev, int ef, logic ec);
        vec_t v;
        v.arm = arm; v.disarm = dis; v.ack = ack;
        v.flow = FW'(flow); v.num = AW'(num); v.rdy = rdy;
        v.exp_val = ev; v.exp_flow = FW'(ef); v.exp_cause = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        arm_val = 0; arm_flowid = '0;
        disarm_val = 0; disarm_flowid = '0;
        ack_val = 0; ack_flowid = '0; ack_num = '0;
    endtask

    // Logs a transfer if one happens at the coming edge, then advances one cycle.
    task automatic step();
        if (rt_req_val === 1'b1 && rt_req_rdy === 1'b1) begin
            grants.push_back('{cyc, int'(rt_req_flowid), int'(rt_req_cause)});
            $display("cycle %0d: grant flow %0d cause %0d", cyc, rt_req_flowid, rt_req_cause);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        grants.delete();
    endtask

    initial begin
        int seen;
        int hold_ok;

        // ---- reset state and idle ----
        rt_req_rdy = 1'b1;
        idle_inputs();
        rst = 1'b1;
        step();
        check("reset_val", rt_req_val, 0);
        check("reset_flowid", rt_req_flowid, 0);
        check("reset_cause", rt_req_cause, 0);
        check("reset_time", curr_time, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (rt_req_val !== 1'b0) seen++;
        end
        check("idle_no_req", seen, 0);
        check("idle_time_300", curr_time, 300);

        // ---- single-flow timeout, periodic ----
        do_reset();
        for (int c = 0; c < 260; c++) begin
            idle_inputs();
            if (c == 10) begin arm_val = 1; arm_flowid = 2; end
            step();
        end
        check("to_count", grants.size(), 2);
        if (grants.size() == 2) begin
            check("to0_flow", grants[0].flow, 2);
            check("to0_cause", grants[0].cause, 0);
            check("to0_window", (grants[0].cyc >= 110 && grants[0].cyc <= 115), 1);
            check("to1_flow", grants[1].flow, 2);
            check("to1_cause", grants[1].cause, 0);
            check("to1_window", (grants[1].cyc >= 210 && grants[1].cyc <= 215), 1);
        end

        // ---- dup-ACK table ----
        vecs[0]  = mk(1,0,0,1,0,   1, 0,0,0);
        vecs[1]  = mk(0,0,1,1,1000,1, 0,0,0);
        vecs[2]  = mk(0,0,1,1,1000,1, 0,0,0);
        vecs[3]  = mk(0,0,1,1,1000,1, 0,0,0);
        vecs[4]  = mk(0,0,1,1,1000,1, 0,0,0);
        vecs[5]  = mk(0,0,0,0,0,   1, 1,1,1);
        vecs[6]  = mk(0,0,1,1,1000,1, 0,0,0);
        vecs[7]  = mk(0,0,0,0,0,   1, 0,0,0);
        vecs[8]  = mk(0,0,0,0,0,   1, 0,0,0);
        vecs[9]  = mk(0,1,0,1,0,   1, 0,0,0);
        vecs[10] = mk(0,0,1,1,1000,1, 0,0,0);
        vecs[11] = mk(0,0,1,1,1000,1, 0,0,0);
        vecs[12] = mk(1,0,0,1,0,   1, 0,0,0);
        vecs[13] = mk(0,0,1,1,1000,1, 0,0,0);
        vecs[14] = mk(0,0,1,1,1000,1, 0,0,0);
        vecs[15] = mk(0,0,1,1,2000,1, 0,0,0);
        vecs[16] = mk(0,0,1,1,2000,1, 0,0,0);
        vecs[17] = mk(0,0,1,1,2000,1, 0,0,0);
        vecs[18] = mk(0,0,1,1,2000,1, 0,0,0);
        vecs[19] = mk(0,0,0,0,0,   0, 1,1,1);
        vecs[20] = mk(0,0,0,0,0,   0, 1,1,1);
        vecs[21] = mk(0,0,0,0,0,   1, 0,0,0);
        vecs[22] = mk(1,1,0,1,0,   1, 0,0,0);
        vecs[23] = mk(0,0,1,1,3000,1, 0,0,0);
        vecs[24] = mk(0,0,1,1,3000,1, 0,0,0);
        vecs[25] = mk(0,0,1,1,3000,1, 0,0,0);
        vecs[26] = mk(0,0,1,1,3000,1, 0,0,0);
        vecs[27] = mk(0,0,0,0,0,   1, 0,0,0);
        vecs[28] = mk(0,0,0,0,0,   1, 0,0,0);
        do_reset();
        for (int i = 0; i < 29; i++) begin
            arm_val = vecs[i].arm;       arm_flowid = vecs[i].flow;
            disarm_val = vecs[i].disarm; disarm_flowid = vecs[i].flow;
            ack_val = vecs[i].ack;       ack_flowid = vecs[i].flow;
            ack_num = vecs[i].num;       rt_req_rdy = vecs[i].rdy;
            step();
            check($sformatf("vec%0d_val", i), rt_req_val, vecs[i].exp_val);
            if (vecs[i].exp_val) begin
                check($sformatf("vec%0d_flow", i), rt_req_flowid, vecs[i].exp_flow);
                check($sformatf("vec%0d_cause", i), rt_req_cause, vecs[i].exp_cause);
            end
        end
        idle_inputs();
        rt_req_rdy = 1'b1;

        // ---- ACK-refreshed flow, arm+disarm collision, disarm of pending flow ----
        do_reset();
        rt_req_rdy = 1'b0;
        hold_ok = 0;
        for (int c = 0; c <= 520; c++) begin
            idle_inputs();
            if (c == 0) begin arm_val = 1; arm_flowid = 2; end
            if (c == 1) begin arm_val = 1; arm_flowid = 3; end
            if (c == 2) begin arm_val = 1; arm_flowid = 0; end
            if (c == 3) begin arm_val = 1; arm_flowid = 1; disarm_val = 1; disarm_flowid = 1; end
            if (c >= 52 && c % 50 == 2) begin ack_val = 1; ack_flowid = 0; ack_num = AW'(c); end
            if (c == 110) begin disarm_val = 1; disarm_flowid = 3; end
            if (c == 120) rt_req_rdy = 1'b1;
            if (c == 121) begin disarm_val = 1; disarm_flowid = 2; end
            if (c >= 104 && c <= 119 && rt_req_val === 1'b1 && rt_req_flowid == 2 && rt_req_cause == 0)
                hold_ok++;
            step();
        end
        check("disarm_hold_cycles", hold_ok, 16);
        check("disarm_grant_count", grants.size(), 1);
        if (grants.size() == 1) begin
            check("disarm_grant_flow", grants[0].flow, 2);
            check("disarm_grant_cycle", grants[0].cyc, 120);
        end

        // ---- all flows time out under backpressure, then round-robin drain ----
        do_reset();
        rt_req_rdy = 1'b0;
        hold_ok = 0;
        for (int c = 0; c < 140; c++) begin
            idle_inputs();
            if (c < 4) begin arm_val = 1; arm_flowid = FW'(c); end
            if (c == 122) rt_req_rdy = 1'b1;
            if (c >= 102 && c <= 121 && rt_req_val === 1'b1 && rt_req_flowid == 0)
                hold_ok++;
            step();
        end
        check("rr_hold_cycles", hold_ok, 20);
        check("rr_grant_count", grants.size(), 4);
        if (grants.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr%0d_flow", i), grants[i].flow, i);
                check($sformatf("rr%0d_cycle", i), grants[i].cyc, 122 + i);
                check($sformatf("rr%0d_cause", i), grants[i].cause, 0);
            end
        end

        // ---- fast retransmit and timeout pending together, then reset ----
        do_reset();
        rt_req_rdy = 1'b1;
        for (int c = 0; c <= 104; c++) begin
            idle_inputs();
            if (c == 0) begin arm_val = 1; arm_flowid = 2; end
            if (c == 1 || (c >= 100 && c <= 102)) begin
                ack_val = 1; ack_flowid = 2; ack_num = 500;
            end
            step();
        end
        check("both_first_count", grants.size(), 1);
        if (grants.size() == 1) begin
            check("both_first_flow", grants[0].flow, 2);
            check("both_first_cause", grants[0].cause, 1);
            check("both_first_cycle", grants[0].cyc, 104);
        end
        check("both_second_val", rt_req_val, 1);
        check("both_second_flow", rt_req_flowid, 2);
        check("both_second_cause", rt_req_cause, 0);
        rst = 1'b1;
        rt_req_rdy = 1'b0;
        step();
        check("midreset_val", rt_req_val, 0);
        check("midreset_flowid", rt_req_flowid, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
